// File: rtl/poc_alu_mc.sv
// Handshaked datapath ALU: single-cycle arithmetic/moves plus iterative
// shift-add multiply and restoring divide, sequenced through busy/done.
module poc_alu_mc #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             lsb,
  output logic             neg,
  output logic             zero,
  output logic             carry,
  output logic             dz
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     ax, bx, sc_res;
  logic               sc_wr, sc_dz;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic               iter_last;

  assign busy = (state != IDLE);
  assign lsb  = c[0];
  assign neg  = c[WIDTH-1];
  assign zero = (c == '0);

  assign ax        = {1'b0, a};
  assign bx        = {1'b0, b};
  assign iter_last = (cnt == CW'(WIDTH));

  // sc_res[WIDTH] doubles as carry-out for adds and borrow for subtracts,
  // and is zero for moves, concatenate and divide-by-zero.
  always_comb begin
    state_next = state;
    sc_res     = '0;
    sc_wr      = 1'b0;
    sc_dz      = 1'b0;
    case (alu_sel)
      4'b0001: begin sc_res = ax; sc_wr = 1'b1; end
      4'b0010: begin sc_res = bx; sc_wr = 1'b1; end
      4'b0011: begin sc_res = bx + (WIDTH+1)'(1); sc_wr = 1'b1; end
      4'b0100: begin sc_res = bx + (WIDTH+1)'(2); sc_wr = 1'b1; end
      4'b0101: begin sc_res = bx + (WIDTH+1)'(3); sc_wr = 1'b1; end
      4'b0110: begin sc_res = bx - (WIDTH+1)'(1); sc_wr = 1'b1; end
      4'b0111: begin sc_res = bx - (WIDTH+1)'(2); sc_wr = 1'b1; end
      4'b1000: begin sc_res = bx - (WIDTH+1)'(3); sc_wr = 1'b1; end
      4'b1001: begin sc_res = bx + ax; sc_wr = 1'b1; end
      4'b1010: begin sc_res = bx - ax; sc_wr = 1'b1; end
      4'b1100: begin
        if (a == '0) begin
          sc_res = {1'b0, {WIDTH{1'b1}}};
          sc_wr  = 1'b1;
          sc_dz  = 1'b1;
        end
      end
      4'b1101: begin sc_res = {1'b0, a[HALF-1:0], b[HALF-1:0]}; sc_wr = 1'b1; end
      default: ;
    endcase

    case (state)
      IDLE: begin
        if (start) begin
          if (alu_sel == 4'b1011)
            state_next = MUL;
          else if (alu_sel == 4'b1100 && a != '0)
            state_next = DIV;
        end
      end
      MUL, DIV: if (iter_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // prod holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      c     <= '0;
      carry <= 1'b0;
      dz    <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
      opnd  <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (alu_sel == 4'b1011) begin
              prod <= {{WIDTH{1'b0}}, a};
              opnd <= b;
              cnt  <= '0;
            end else if (alu_sel == 4'b1100 && a != '0) begin
              prod <= {{WIDTH{1'b0}}, b};
              opnd <= a;
              cnt  <= '0;
            end else begin
              done <= 1'b1;
              if (sc_wr) begin
                c     <= sc_res[WIDTH-1:0];
                carry <= sc_res[WIDTH];
                dz    <= sc_dz;
              end
            end
          end
        end
        MUL: begin
          if (iter_last) begin
            c     <= prod[WIDTH-1:0];
            carry <= |prod[2*WIDTH-1:WIDTH];
            dz    <= 1'b0;
            done  <= 1'b1;
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
          end
        end
        DIV: begin
          if (iter_last) begin
            c     <= prod[WIDTH-1:0];
            carry <= 1'b0;
            dz    <= 1'b0;
            done  <= 1'b1;
          end else begin
            prod <= {div_rem, prod[WIDTH-2:0], div_ge};
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_poc_alu_mc.sv
// Self-checking bench for poc_alu_mc: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_poc_alu_mc;
  localparam int W    = 18;
  localparam int HALF = W / 2;
  localparam longint MASK  = (longint'(1) << W) - 1;
  localparam longint HMASK = (longint'(1) << HALF) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alu_sel = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] c;
  logic         busy, done, lsb, neg, zero, carry, dz;

  int checks = 0;
  int errors = 0;

  longint m_c = 0;
  logic   m_carry = 1'b0, m_dz = 1'b0;

  poc_alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_sel(alu_sel),
    .a(a), .b(b), .c(c), .busy(busy), .done(done),
    .lsb(lsb), .neg(neg), .zero(zero), .carry(carry), .dz(dz)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic on wide integers; commits the expected state.
  task automatic model(input logic [3:0] sel, input longint av, input longint bv,
                       output longint ec, output logic ecar, output logic edz,
                       output logic emul);
    longint r;
    int k;
    ec = m_c; ecar = m_carry; edz = m_dz; emul = 1'b0;
    k = int'(sel);
    if (k == 1) begin ec = av; ecar = 0; edz = 0; end
    else if (k == 2) begin ec = bv; ecar = 0; edz = 0; end
    else if (k >= 3 && k <= 5) begin
      r = bv + (k - 2); ecar = (r > MASK); edz = 0; ec = r & MASK;
    end else if (k >= 6 && k <= 8) begin
      r = bv - (k - 5); ecar = (r < 0); edz = 0; ec = r & MASK;
    end else if (k == 9) begin
      r = bv + av; ecar = (r > MASK); edz = 0; ec = r & MASK;
    end else if (k == 10) begin
      r = bv - av; ecar = (r < 0); edz = 0; ec = r & MASK;
    end else if (k == 11) begin
      r = bv * av; ec = r & MASK; ecar = ((r >> W) != 0); edz = 0; emul = 1'b1;
    end else if (k == 12) begin
      if (av == 0) begin ec = MASK; ecar = 0; edz = 1; end
      else begin ec = bv / av; ecar = 0; edz = 0; emul = 1'b1; end
    end else if (k == 13) begin
      ec = ((av & HMASK) << HALF) | (bv & HMASK); ecar = 0; edz = 0;
    end
    m_c = ec; m_carry = ecar; m_dz = edz;
  endtask

  // Issue one op, optionally poke a stray start while busy, then check result.
  task automatic run_op(input logic [3:0] sel, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int poke, input string tag);
    longint ec;
    logic ecar, edz, emul;
    int nb, exp_nb;
    model(sel, longint'(av), longint'(bv), ec, ecar, edz, emul);
    @(negedge clk);
    start = 1'b1; alu_sel = sel; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; alu_sel = 4'($urandom); a = W'($urandom); b = W'($urandom);
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      if (nb == poke) begin start = 1'b1; alu_sel = 4'b0001; a = 9; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    exp_nb = emul ? W + 1 : 0;
    checks++; if (nb !== exp_nb) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, nb, exp_nb); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done: got %b expected 1", tag, done); end
    checks++; if (c !== ec[W-1:0]) begin errors++; $display("FAIL %s c: got %h expected %h", tag, c, ec[W-1:0]); end
    checks++; if (carry !== ecar) begin errors++; $display("FAIL %s carry: got %b expected %b", tag, carry, ecar); end
    checks++; if (dz !== edz) begin errors++; $display("FAIL %s dz: got %b expected %b", tag, dz, edz); end
    checks++; if (lsb !== ec[0] || neg !== ec[W-1] || zero !== (ec == 0)) begin
      errors++; $display("FAIL %s flags: got lsb=%b neg=%b zero=%b expected lsb=%b neg=%b zero=%b",
                         tag, lsb, neg, zero, ec[0], ec[W-1], ec == 0);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse: got %b expected 0", tag, done); end
    checks++; if (c !== ec[W-1:0] || busy !== 1'b0) begin
      errors++; $display("FAIL %s hold: got c=%h busy=%b expected c=%h busy=0", tag, c, busy, ec[W-1:0]);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (c !== '0 || carry !== 1'b0 || dz !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset: got c=%h carry=%b dz=%b busy=%b done=%b expected all 0", c, carry, dz, busy, done);
    end
    rst_n = 1'b1;
    m_c = 0; m_carry = 0; m_dz = 0;
  endtask

  task automatic test_add_sub;
    run_op(4'b1001, 18'd5, 18'd7, 0, "add");
    run_op(4'b0011, 18'd0, 18'h3FFFF, 0, "inc_wrap");
    run_op(4'b1010, 18'd7, 18'd5, 0, "sub_borrow");
    run_op(4'b1000, 18'd0, 18'd2, 0, "dec3_borrow");
  endtask

  task automatic test_mul;
    run_op(4'b1011, 18'd300, 18'd400, 6, "mul_ignore_start");
    run_op(4'b1011, 18'd1024, 18'd1024, 0, "mul_overflow");
  endtask

  task automatic test_div;
    run_op(4'b1100, 18'd7, 18'd1000, 0, "div");
    run_op(4'b1100, 18'd0, 18'd55, 0, "div_zero");
    run_op(4'b1100, 18'd1, 18'h3FFFF, 0, "div_by_one");
  endtask

  task automatic test_concat_undef;
    run_op(4'b1101, 18'h00123, 18'h000AB, 0, "concat");
    run_op(4'b1111, 18'h1, 18'h2, 0, "undef_1111");
    run_op(4'b0000, 18'h5, 18'h6, 0, "undef_0000");
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    start = 1'b1; alu_sel = 4'b1011; a = 3; b = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (c !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got c=%h busy=%b done=%b expected 0 0 0", c, busy, done);
    end
    rst_n = 1'b1;
    m_c = 0; m_carry = 0; m_dz = 0;
    run_op(4'b1011, 18'd3, 18'd3, 0, "rerun_mul");
  endtask

  task automatic test_back_to_back;
    longint ec1, ec2;
    logic ecar, edz, emul;
    int nb;
    logic [W-1:0] av, bv;
    av = W'($urandom_range(1, 511)); bv = W'($urandom_range(1, 511));
    model(4'b1011, longint'(av), longint'(bv), ec1, ecar, edz, emul);
    @(negedge clk);
    start = 1'b1; alu_sel = 4'b1011; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy && nb < 200) begin nb++; @(negedge clk); end
    checks++; if (done !== 1'b1 || c !== ec1[W-1:0]) begin
      errors++; $display("FAIL b2b first: got done=%b c=%h expected done=1 c=%h", done, c, ec1[W-1:0]);
    end
    av = W'($urandom); bv = W'($urandom);
    model(4'b1001, longint'(av), longint'(bv), ec2, ecar, edz, emul);
    start = 1'b1; alu_sel = 4'b1001; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || c !== ec2[W-1:0] || carry !== ecar) begin
      errors++; $display("FAIL b2b second: got done=%b busy=%b c=%h carry=%b expected 1 0 %h %b",
                         done, busy, c, carry, ec2[W-1:0], ecar);
    end
  endtask

  task automatic test_random;
    logic [3:0] sel;
    logic [W-1:0] av, bv;
    for (int i = 0; i < 40; i++) begin
      sel = 4'($urandom);
      av  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      bv  = W'($urandom);
      run_op(sel, av, bv, 0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_mul;
    test_div;
    test_concat_undef;
    test_back_to_back;
    test_reset_mid_op;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
